// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing defaults, colour mode and pixel types for the VGA scan-out
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_PIX_W    = 4;

  typedef enum logic {
    CM_GRAY = 1'b0,
    CM_RGB  = 1'b1
  } color_mode_e;

  typedef struct packed {
    logic [VGA_PIX_W-1:0] r;
    logic [VGA_PIX_W-1:0] g;
    logic [VGA_PIX_W-1:0] b;
  } rgb_t;

  // Shift amount for an upscale factor; only 1, 2 and 4 are meaningful.
  function automatic int scale_shift(input int scale);
    return (scale == 4) ? 2 : (scale == 2) ? 1 : 0;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - fixed-depth shift register aligning control flags with pixel data
module vga_delay_line #(
  parameter int              DEPTH     = 1,
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk24,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift din through DEPTH stages; reset parks every stage at the idle value.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_out.sv
// rtl/vga_scan_out.sv - VGA timing, upscaled frame-buffer addressing and pixel output
module vga_scan_out
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE     = VGA_H_ACTIVE,
  parameter int   H_FP         = VGA_H_FP,
  parameter int   H_SYNC       = VGA_H_SYNC,
  parameter int   H_BP         = VGA_H_BP,
  parameter int   V_ACTIVE     = VGA_V_ACTIVE,
  parameter int   V_FP         = VGA_V_FP,
  parameter int   V_SYNC       = VGA_V_SYNC,
  parameter int   V_BP         = VGA_V_BP,
  parameter logic HSYNC_ACTIVE = 1'b0,
  parameter logic VSYNC_ACTIVE = 1'b0,
  parameter int   PIX_W        = VGA_PIX_W,
  parameter int   SCALE        = 1,
  parameter int   RD_LAT       = 1,
  parameter int   FB_AW        = 19,
  parameter int   OVL_SIZE     = 32
) (
  input  logic               clk24,
  input  logic               rst_n,
  input  logic [3*PIX_W-1:0] fb_pixel,
  input  logic               color_mode,
  input  logic               ovl_en,
  input  logic [3*PIX_W-1:0] ovl_color,
  output logic [FB_AW-1:0]   fb_addr,
  output logic               fb_rd,
  output logic [PIX_W-1:0]   vga_red,
  output logic [PIX_W-1:0]   vga_green,
  output logic [PIX_W-1:0]   vga_blue,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic               frame_start
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW        = $clog2(H_TOTAL + 1);
  localparam int VW        = $clog2(V_TOTAL + 1);
  localparam int SH        = scale_shift(SCALE);
  localparam int FB_W      = H_ACTIVE / SCALE;
  localparam int LAT_TOTAL = RD_LAT + 2;

  localparam logic [HW-1:0]    H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]    V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [FB_AW-1:0] FB_W_A  = FB_AW'(FB_W);

  if (!(SCALE == 1 || SCALE == 2 || SCALE == 4)) begin : g_bad_scale
    $error("vga_scan_out: SCALE must be 1, 2 or 4");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("vga_scan_out: RD_LAT must be within 1..4");
  end
  if ((H_ACTIVE % SCALE) != 0 || (V_ACTIVE % SCALE) != 0) begin : g_bad_div
    $error("vga_scan_out: active size not divisible by SCALE");
  end
  if (longint'(FB_W) * longint'(V_ACTIVE / SCALE) > (longint'(1) << FB_AW)) begin : g_bad_aw
    $error("vga_scan_out: frame buffer does not fit in FB_AW bits");
  end

  logic [HW-1:0]      h;
  logic [VW-1:0]      v;
  logic [FB_AW-1:0]   row_base;
  logic               active;
  logic               frame_end;
  logic               last_sub_line;
  color_mode_e        cm_sh;
  logic               ovl_en_sh;
  logic [3*PIX_W-1:0] ovl_color_sh;
  logic               hs_flag;
  logic               vs_flag;
  logic               fs_flag;
  logic               ovl_hit;
  logic [2:0]         sync_q;
  logic [1:0]         pix_flag_q;

  assign active        = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
  assign frame_end     = (h == H_LAST) && (v == V_LAST);
  assign last_sub_line = (int'(v) % SCALE) == (SCALE - 1);

  assign hs_flag = (int'(h) >= H_ACTIVE + H_FP && int'(h) < H_ACTIVE + H_FP + H_SYNC)
                   ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
  assign vs_flag = (int'(v) >= V_ACTIVE + V_FP && int'(v) < V_ACTIVE + V_FP + V_SYNC)
                   ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
  assign fs_flag = (h == '0) && (v == '0);
  assign ovl_hit = ovl_en_sh && (int'(h) < OVL_SIZE) && (int'(v) < OVL_SIZE);

  // Raster counters; the row base steps once per SCALE active lines so no multiply is needed.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      h        <= '0;
      v        <= '0;
      row_base <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      if (v == V_LAST) begin
        v        <= '0;
        row_base <= '0;
      end else begin
        v <= v + VW'(1);
        if (int'(v) < V_ACTIVE && last_sub_line) row_base <= row_base + FB_W_A;
      end
    end else begin
      h <= h + HW'(1);
    end
  end

  // Registered read request for the current raster position.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      fb_addr <= '0;
      fb_rd   <= 1'b0;
    end else begin
      fb_rd   <= active;
      fb_addr <= active ? row_base + FB_AW'(h >> SH) : '0;
    end
  end

  // Controls only change as the raster wraps, so a frame is always drawn with one setting.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      cm_sh        <= CM_GRAY;
      ovl_en_sh    <= 1'b0;
      ovl_color_sh <= '0;
    end else if (frame_end) begin
      cm_sh        <= color_mode_e'(color_mode);
      ovl_en_sh    <= ovl_en;
      ovl_color_sh <= ovl_color;
    end
  end

  vga_delay_line #(
    .DEPTH     (LAT_TOTAL),
    .WIDTH     (3),
    .RESET_VAL ({~HSYNC_ACTIVE, ~VSYNC_ACTIVE, 1'b0})
  ) u_sync_dly (
    .clk24 (clk24),
    .rst_n (rst_n),
    .din   ({hs_flag, vs_flag, fs_flag}),
    .dout  (sync_q)
  );

  // One stage shorter: the pixel output register supplies the last stage.
  vga_delay_line #(
    .DEPTH     (LAT_TOTAL - 1),
    .WIDTH     (2),
    .RESET_VAL (2'b10)
  ) u_pix_dly (
    .clk24 (clk24),
    .rst_n (rst_n),
    .din   ({~active, ovl_hit}),
    .dout  (pix_flag_q)
  );

  assign vga_hsync   = sync_q[2];
  assign vga_vsync   = sync_q[1];
  assign frame_start = sync_q[0];

  // Pixel output: blank beats overlay beats frame-buffer data.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      {vga_red, vga_green, vga_blue} <= '0;
    end else if (pix_flag_q[1]) begin
      {vga_red, vga_green, vga_blue} <= '0;
    end else if (pix_flag_q[0]) begin
      {vga_red, vga_green, vga_blue} <= ovl_color_sh;
    end else if (cm_sh == CM_RGB) begin
      {vga_red, vga_green, vga_blue} <= fb_pixel;
    end else begin
      {vga_red, vga_green, vga_blue} <= {3{fb_pixel[PIX_W-1:0]}};
    end
  end

endmodule

// File: tb/tb_vga_scan_out.sv
// tb/tb_vga_scan_out.sv - directed self-checking bench for vga_scan_out
module tb_vga_scan_out;
  import vga_pkg::*;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 8, VFP = 1, VSW = 2, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int OVL = 4;

  logic        clk24;
  logic        rst_n;
  logic        color_mode;
  logic        ovl_en;
  logic [11:0] ovl_color;
  logic        fb_force;

  logic [11:0] fb_pixel0, fb_pixel1;
  logic [18:0] fb_addr0, fb_addr1;
  logic        fb_rd0, fb_rd1;
  logic [3:0]  r0, g0, b0, r1, g1, b1;
  logic        hs0, vs0, fs0, hs1, vs1, fs1;

  logic [11:0] mem0_q [3];
  logic [11:0] mem1_q;

  int          cyc;
  int          checks;
  int          failures;
  logic        m_cm;
  logic        m_ovl_en;
  logic [11:0] m_ovl_color;

  vga_scan_out #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HSYNC_ACTIVE(1'b0), .VSYNC_ACTIVE(1'b0), .PIX_W(4),
    .SCALE(2), .RD_LAT(3), .FB_AW(19), .OVL_SIZE(OVL)
  ) dut0 (
    .clk24(clk24), .rst_n(rst_n), .fb_pixel(fb_pixel0), .color_mode(color_mode),
    .ovl_en(ovl_en), .ovl_color(ovl_color), .fb_addr(fb_addr0), .fb_rd(fb_rd0),
    .vga_red(r0), .vga_green(g0), .vga_blue(b0),
    .vga_hsync(hs0), .vga_vsync(vs0), .frame_start(fs0)
  );

  vga_scan_out #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HSYNC_ACTIVE(1'b1), .VSYNC_ACTIVE(1'b0), .PIX_W(4),
    .SCALE(1), .RD_LAT(1), .FB_AW(19), .OVL_SIZE(OVL)
  ) dut1 (
    .clk24(clk24), .rst_n(rst_n), .fb_pixel(fb_pixel1), .color_mode(color_mode),
    .ovl_en(ovl_en), .ovl_color(ovl_color), .fb_addr(fb_addr1), .fb_rd(fb_rd1),
    .vga_red(r1), .vga_green(g1), .vga_blue(b1),
    .vga_hsync(hs1), .vga_vsync(vs1), .frame_start(fs1)
  );

  initial clk24 = 1'b0;
  always #5 clk24 = ~clk24;

  // Behavioural frame buffers: data = addr[11:0], returned RD_LAT cycles after the address.
  always @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      mem0_q[0] <= '0;
      mem0_q[1] <= '0;
      mem0_q[2] <= '0;
      mem1_q    <= '0;
    end else begin
      mem0_q[0] <= fb_addr0[11:0];
      mem0_q[1] <= mem0_q[0];
      mem0_q[2] <= mem0_q[1];
      mem1_q    <= fb_addr1[11:0];
    end
  end

  assign fb_pixel0 = fb_force ? 12'hABC : mem0_q[2];
  assign fb_pixel1 = fb_force ? 12'hABC : mem1_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_dut(input int id, input int sc, input int lat, input logic hs_act,
                           input logic [18:0] addr, input logic rd,
                           input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                           input logic hs, input logic vs, input logic fs);
    int   ap, ah, av, op, oh, ov, ea, oa;
    bit   a_ok, o_ok, er;
    rgb_t ep;
    logic [11:0] d;
    logic exp_hs, exp_vs;
    a_ok = cyc >= 1;
    ap = a_ok ? (cyc - 1) % FRAME : 0;
    ah = ap % HT;
    av = ap / HT;
    if (a_ok && ah < HA && av < VA) begin
      ea = (av / sc) * (HA / sc) + ah / sc;
      er = 1'b1;
    end else begin
      ea = 0;
      er = 1'b0;
    end
    o_ok = cyc >= lat + 2;
    op = o_ok ? (cyc - lat - 2) % FRAME : 0;
    oh = op % HT;
    ov = op / HT;
    exp_hs = (o_ok && oh >= HA + HFP && oh < HA + HFP + HSW) ? hs_act : ~hs_act;
    exp_vs = (o_ok && ov >= VA + VFP && ov < VA + VFP + VSW) ? 1'b0 : 1'b1;
    if (!o_ok || oh >= HA || ov >= VA) begin
      ep = '0;
    end else if (m_ovl_en && oh < OVL && ov < OVL) begin
      ep = m_ovl_color;
    end else begin
      oa = (ov / sc) * (HA / sc) + oh / sc;
      d  = fb_force ? 12'hABC : oa[11:0];
      ep = m_cm ? d : {d[3:0], d[3:0], d[3:0]};
    end
    chk($sformatf("d%0d_fb_addr", id), 32'(addr), ea);
    chk($sformatf("d%0d_fb_rd", id), 32'(rd), 32'(er));
    chk($sformatf("d%0d_rgb", id), 32'({r, g, b}), 32'(ep));
    chk($sformatf("d%0d_hsync", id), 32'(hs), 32'(exp_hs));
    chk($sformatf("d%0d_vsync", id), 32'(vs), 32'(exp_vs));
    chk($sformatf("d%0d_frame_start", id), 32'(fs), 32'(o_ok && op == 0));
  endtask

  task automatic check_both();
    check_dut(0, 2, 3, 1'b0, fb_addr0, fb_rd0, r0, g0, b0, hs0, vs0, fs0);
    check_dut(1, 1, 1, 1'b1, fb_addr1, fb_rd1, r1, g1, b1, hs1, vs1, fs1);
  endtask

  task automatic step();
    if (cyc % FRAME == FRAME - 1) begin
      m_cm        = color_mode;
      m_ovl_en    = ovl_en;
      m_ovl_color = ovl_color;
    end
    @(posedge clk24);
    #1;
    cyc++;
    check_both();
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic model_reset();
    cyc         = 0;
    m_cm        = 1'b0;
    m_ovl_en    = 1'b0;
    m_ovl_color = '0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b1;
    color_mode = 1'b0;
    ovl_en = 1'b0;
    ovl_color = '0;
    fb_force = 1'b0;
    model_reset();
    #1;
    rst_n = 1'b0;
    #1;
    check_both();
    repeat (3) @(posedge clk24);
    #1;
    check_both();
    rst_n = 1'b1;

    run_to(2);
    chk("d1_first_pixel_not_yet", 32'(fs1), 32'd0);
    run_to(3);
    chk("d1_frame_start_at_L3", 32'(fs1), 32'd1);
    run_to(4);
    chk("d0_blank_before_L", 32'(fs0), 32'd0);
    run_to(5);
    chk("d0_frame_start_at_L5", 32'(fs0), 32'd1);
    run_to(22);
    chk("d0_hsync_before", 32'(hs0), 32'd1);
    run_to(23);
    chk("d0_hsync_first", 32'(hs0), 32'd0);
    chk("d1_hsync_last", 32'(hs1), 32'd1);
    run_to(24);
    chk("d1_hsync_after", 32'(hs1), 32'd0);
    run_to(25);
    chk("d0_line1_addr0", 32'(fb_addr0), 32'd0);
    chk("d0_hsync_third", 32'(hs0), 32'd0);
    run_to(26);
    chk("d0_hsync_after", 32'(hs0), 32'd1);
    run_to(49);
    chk("d0_line2_base", 32'(fb_addr0), 32'd8);
    run_to(184);
    chk("d0_last_addr", 32'(fb_addr0), 32'd31);
    chk("d0_last_rd", 32'(fb_rd0), 32'd1);
    run_to(185);
    chk("d0_rd_blank", 32'(fb_rd0), 32'd0);
    run_to(220);
    chk("d0_vsync_before", 32'(vs0), 32'd1);
    run_to(221);
    chk("d0_vsync_first", 32'(vs0), 32'd0);
    run_to(320);
    chk("d0_gray_3_0", 32'({r0, g0, b0}), 32'h111);

    run_to(412);
    color_mode = 1'b1;
    ovl_en = 1'b1;
    ovl_color = 12'hF00;
    run_to(425);
    chk("d0_still_gray", 32'({r0, g0, b0}), 32'h666);
    run_to(628);
    chk("d0_blank_pre_frame", 32'({r0, g0, b0}), 32'h000);
    run_to(629);
    chk("d0_ovl_0_0", 32'({r0, g0, b0}), 32'hF00);
    chk("d0_fs_frame2", 32'(fs0), 32'd1);
    run_to(633);
    chk("d0_rgb_4_0", 32'({r0, g0, b0}), 32'h002);
    run_to(725);
    chk("d0_rgb_0_4", 32'({r0, g0, b0}), 32'h010);
    run_to(888);
    fb_force = 1'b1;
    run_to(946);
    chk("d0_rgb_abc", 32'({r0, g0, b0}), 32'hABC);
    chk("d1_rgb_abc", 32'({r1, g1, b1}), 32'hABC);

    run_to(4 * FRAME + 130);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_both();
    repeat (2) @(posedge clk24);
    #1;
    check_both();
    rst_n = 1'b1;
    run_to(1);
    chk("d0_restart_addr", 32'(fb_addr0), 32'd0);
    chk("d0_restart_rd", 32'(fb_rd0), 32'd1);
    run_to(10);
    chk("d0_gray_after_reset", 32'({r0, g0, b0}), 32'hCCC);
    run_to(FRAME + 5);
    chk("d0_fs_period", 32'(fs0), 32'd1);
    chk("d0_ovl_after_reset", 32'({r0, g0, b0}), 32'hF00);
    run_to(FRAME + 10);
    chk("d0_rgb_after_reset", 32'({r0, g0, b0}), 32'hABC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
